// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared constants for the instruction-memory boot loader.
//   IMEM_ADDR_W    : word-address width of the instruction memory. The core's
//                    memory instance uses the same value, so both always agree.
//   DEFAULT_CNT_W  : width of the header word-count field.
//   ST_*           : loader FSM state encoding.
//   state_takes_bytes() : true for states in which the loader accepts bytes.
// -----------------------------------------------------------------------------
package imem_loader_pkg;

  localparam int IMEM_ADDR_W   = 12;
  localparam int DEFAULT_CNT_W = 16;

  localparam logic [2:0] ST_HDR0 = 3'd0;  // expecting count[15:8]
  localparam logic [2:0] ST_HDR1 = 3'd1;  // expecting count[7:0]
  localparam logic [2:0] ST_WORD = 3'd2;  // streaming image bytes
  localparam logic [2:0] ST_CSUM = 3'd3;  // expecting trailing checksum byte
  localparam logic [2:0] ST_DONE = 3'd4;  // image loaded, core released
  localparam logic [2:0] ST_ERR  = 3'd5;  // load aborted, core held

  function automatic logic state_takes_bytes(input logic [2:0] s);
    return (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_WORD) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Bundles the byte-stream handshake, the instruction-memory write port and the
// loader status lines.
//   in_valid/in_data/in_ready : byte source handshake (transfer = valid & ready)
//   mem_addr/mem_wdata/mem_we : instruction-memory spare write port
//   cpu_rst/busy/done/err     : core reset hold and load status
// Modports:
//   master : byte source / system side (drives the byte stream, sees the rest)
//   slave  : the loader itself
// -----------------------------------------------------------------------------
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
);

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_addr, mem_wdata, mem_we, cpu_rst, busy, done, err
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_addr, mem_wdata, mem_we, cpu_rst, busy, done, err
  );

endinterface

// File: rtl/imem_loader_asm.sv
// -----------------------------------------------------------------------------
// imem_loader_asm
// Byte-to-word assembler. Collects four accepted bytes little-endian (byte k
// lands in bits [8k+7:8k]) and flags the cycle in which the fourth byte is
// accepted; the complete word is presented combinationally in that cycle so the
// parent can register it straight into the memory write port.
// Ports:
//   clk, rst_async : clock, asynchronous active-high reset
//   i_byte_valid   : a byte is accepted this cycle
//   i_byte         : the accepted byte
//   o_word_valid   : this cycle's byte completes a word
//   o_word         : assembled word (valid while o_word_valid is high)
// -----------------------------------------------------------------------------
module imem_loader_asm (
  input  logic        clk,
  input  logic        rst_async,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [1:0]  r_idx;    // index of the next byte within the word
  logic [23:0] r_shift;  // bytes 0..2 of the word under assembly

  // NOTE: the partial-word register is ordinary flops, not a RAM, so it takes
  // the reset like everything else and an aborted load leaves no stale bytes.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      r_idx   <= 2'd0;
      r_shift <= 24'd0;
    end else if (i_byte_valid) begin
      r_idx <= r_idx + 2'd1;
      case (r_idx)
        2'd0:    r_shift[7:0]   <= i_byte;
        2'd1:    r_shift[15:8]  <= i_byte;
        2'd2:    r_shift[23:16] <= i_byte;
        default: ;  // byte 3 goes straight out through o_word
      endcase
    end
  end

  assign o_word_valid = i_byte_valid && (r_idx == 2'd3);
  assign o_word       = {i_byte, r_shift};

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Boot-time writer for the 32-bit instruction memory. Receives a byte stream
// (2-byte big-endian word count N, then 4*N little-endian word bytes), writes
// the words to addresses 0..N-1 and holds the core in reset until the image is
// complete. A count above the memory capacity aborts the load.
// Optional feature (macro IMEM_LOADER_CHECKSUM_EN): an 8-bit running sum over
// every accepted byte plus one trailing byte must total 0 mod 256, otherwise
// the load ends in error and the core stays in reset.
// Ports:
//   clk       : system clock
//   rst_async : asynchronous, active-high reset
//   bus       : imem_loader_if slave modport (byte handshake, memory write
//               port, cpu_rst/busy/done/err status)
// Parameters:
//   ADDR_W : instruction-memory word-address width (capacity 2**ADDR_W words)
//   CNT_W  : header word-count width, at least ADDR_W+1
// -----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic         clk,
  input  logic         rst_async,
  imem_loader_if.slave bus
);

  localparam logic [CNT_W:0] CNT_ONE  = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W:0] CAPACITY = CNT_ONE << ADDR_W;

  // Where the FSM goes once the last word (or an empty header) is through.
  localparam logic [2:0] ST_AFTER_LOAD =
`ifdef IMEM_LOADER_CHECKSUM_EN
    ST_CSUM;
`else
    ST_DONE;
`endif

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic              r_in_ready;
  logic [7:0]        r_cnt_hi;   // count[15:8] captured in HDR0
  logic [CNT_W-1:0]  r_n;        // header word count
  logic [CNT_W:0]    r_wr_cnt;   // words written so far; one bit wider so N=capacity fits
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_mem_we;
  logic              r_cpu_rst;

  logic              w_xfer;
  logic              w_byte_valid;
  logic              w_word_valid;
  logic [31:0]       w_word;
  logic [CNT_W-1:0]  w_hdr_n;
  logic              w_hdr_zero;
  logic              w_hdr_too_big;
  logic [CNT_W:0]    w_wr_cnt_inc;
  logic              w_last_word;

  assign w_xfer        = bus.in_valid && r_in_ready;
  assign w_byte_valid  = w_xfer && (r_state == ST_WORD);
  assign w_hdr_n       = CNT_W'({r_cnt_hi, bus.in_data});
  assign w_hdr_zero    = (w_hdr_n == '0);
  assign w_hdr_too_big = ({1'b0, w_hdr_n} > CAPACITY);
  assign w_wr_cnt_inc  = r_wr_cnt + CNT_ONE;
  assign w_last_word   = w_word_valid && (w_wr_cnt_inc == {1'b0, r_n});

  imem_loader_asm u_asm (
    .clk          (clk),
    .rst_async    (rst_async),
    .i_byte_valid (w_byte_valid),
    .i_byte       (bus.in_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic [7:0] w_sum_nxt;

  assign w_sum_nxt = r_sum + bus.in_data;

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async)   r_sum <= 8'd0;
    else if (w_xfer) r_sum <= w_sum_nxt;
  end
`endif

  // NOTE: every output of a combinational block gets a default before the
  // case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_HDR0: if (w_xfer) w_state_nxt = ST_HDR1;
      ST_HDR1: begin
        if (w_xfer) begin
          if (w_hdr_zero)         w_state_nxt = ST_AFTER_LOAD;
          else if (w_hdr_too_big) w_state_nxt = ST_ERR;
          else                    w_state_nxt = ST_WORD;
        end
      end
      ST_WORD: if (w_last_word) w_state_nxt = ST_AFTER_LOAD;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM: if (w_xfer) w_state_nxt = (w_sum_nxt == 8'd0) ? ST_DONE : ST_ERR;
`endif
      ST_DONE, ST_ERR: w_state_nxt = r_state;
      default:         w_state_nxt = ST_ERR;  // unused encodings fail safe
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      r_state     <= ST_HDR0;
      r_in_ready  <= 1'b0;
      r_cnt_hi    <= 8'd0;
      r_n         <= '0;
      r_wr_cnt    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
      r_mem_we    <= 1'b0;
      r_cpu_rst   <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      // in_ready is registered: it reflects whether the state being entered
      // takes bytes, so it is already high in the write cycle of a mid-image
      // word and already low in the first DONE/ERR cycle.
      r_in_ready <= state_takes_bytes(w_state_nxt);
      r_mem_we   <= w_word_valid;
      if (w_xfer && (r_state == ST_HDR0)) r_cnt_hi <= bus.in_data;
      if (w_xfer && (r_state == ST_HDR1)) r_n      <= w_hdr_n;
      if (w_word_valid) begin
        r_mem_addr  <= r_wr_cnt[ADDR_W-1:0];
        r_mem_wdata <= w_word;
        r_wr_cnt    <= w_wr_cnt_inc;
      end
      // Released one cycle after DONE, i.e. after the final write has landed.
      r_cpu_rst <= (r_state != ST_DONE);
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_we    = r_mem_we;
  assign bus.cpu_rst   = r_cpu_rst;
  assign bus.busy      = (r_state == ST_WORD) || (r_state == ST_CSUM);
  assign bus.done      = (r_state == ST_DONE);
  assign bus.err       = (r_state == ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader (default ADDR_W=12, CNT_W=16). Builds
// with or without IMEM_LOADER_CHECKSUM_EN; the reference model appends the
// correct checksum byte when the option is enabled.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int AW    = 12;
  localparam int CAP   = 1 << AW;
  localparam int LIMIT = 20;  // max cycles to wait for in_ready per byte

  logic clk = 1'b0;
  logic rst_async = 1'b0;

  imem_loader_if #(.ADDR_W(AW)) bus ();

  imem_loader #(.ADDR_W(AW), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_async (rst_async),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- monitor
  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic          rdy;   // in_ready during the write cycle
  } wr_t;

  wr_t wr_q[$];

  always @(negedge clk)
    if (bus.mem_we === 1'b1) wr_q.push_back('{bus.mem_addr, bus.mem_wdata, bus.in_ready});

  // ---------------------------------------------------------------- scoring
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  logic [7:0]  stim_q[$];
  logic [31:0] exp_words[$];
  logic        hdr_busy;

  // Appends the checksum byte that makes the running sum zero (option only).
  task automatic add_checksum();
`ifdef IMEM_LOADER_CHECKSUM_EN
    int unsigned sum = 0;
    foreach (stim_q[i]) sum += stim_q[i];
    stim_q.push_back(8'((256 - (sum % 256)) % 256));
`endif
  endtask

  // Builds a stream for word count n with random image bytes and the words
  // the memory should receive.
  task automatic model_load(input logic [15:0] n);
    logic [31:0] w;
    stim_q.delete();
    exp_words.delete();
    stim_q.push_back(n[15:8]);
    stim_q.push_back(n[7:0]);
    if (int'(n) <= CAP) begin
      for (int i = 0; i < 4 * int'(n); i++) stim_q.push_back(8'($urandom_range(0, 255)));
      for (int i = 0; i < int'(n); i++) begin
        w = 32'(stim_q[2+4*i]) + (32'(stim_q[3+4*i]) << 8)
          + (32'(stim_q[4+4*i]) << 16) + (32'(stim_q[5+4*i]) << 24);
        exp_words.push_back(w);
      end
      add_checksum();
    end
  endtask

  // ---------------------------------------------------------------- driver
  task automatic apply_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    @(negedge clk);
    rst_async = 1'b1;
    repeat (2) @(negedge clk);
    rst_async = 1'b0;
    @(negedge clk);  // in_ready has risen by now
    wr_q.delete();
  endtask

  // Presents one byte and returns at the negedge after it was accepted.
  task automatic send_byte(input logic [7:0] b, input bit gaps, output int waited);
    waited = 0;
    if (gaps) begin
      int g = $urandom_range(0, 2);
      for (int k = 0; k < g; k++) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom_range(0, 255));
        @(negedge clk);
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && waited < LIMIT) begin
      @(negedge clk);
      waited++;
    end
    if (bus.in_ready !== 1'b1) check("accept_timeout", 32'(bus.in_ready), 32'd1);
    else @(negedge clk);
  endtask

  task automatic drive_stream(input bit gaps, output int total_wait);
    int w;
    total_wait = 0;
    hdr_busy   = 1'b0;
    for (int i = 0; i < stim_q.size(); i++) begin
      send_byte(stim_q[i], gaps, w);
      total_wait += w;
      if (w >= LIMIT) break;
      if (i == 1) hdr_busy = bus.busy;
    end
  endtask

  task automatic check_writes(input string tag);
    int n = (wr_q.size() < exp_words.size()) ? wr_q.size() : exp_words.size();
    check({tag, ".n_writes"}, 32'(wr_q.size()), 32'(exp_words.size()));
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s.addr%0d", tag, i), 32'(wr_q[i].addr), 32'(i));
      check($sformatf("%s.data%0d", tag, i), wr_q[i].data, exp_words[i]);
    end
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    string       name;
    logic [15:0] n;
    bit          gaps;
    bit          exp_done;
    bit          exp_err;
    int          exp_writes;
  } vec_t;

  vec_t tbl[7];

  task automatic fixed_stream(input bit gaps, input string tag);
    int tw;
    apply_reset();
    stim_q    = '{8'h00, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    exp_words = '{32'h12345678, 32'hDEADBEEF};
    add_checksum();
    drive_stream(gaps, tw);
    bus.in_valid = 1'b0;
    // First cycle in DONE: core still held, no more bytes taken.
    check({tag, ".done"}, 32'(bus.done), 32'd1);
    check({tag, ".cpu_rst_hold"}, 32'(bus.cpu_rst), 32'd1);
    check({tag, ".in_ready_done"}, 32'(bus.in_ready), 32'd0);
`ifndef IMEM_LOADER_CHECKSUM_EN
    check({tag, ".last_we"}, 32'(bus.mem_we), 32'd1);
`endif
    if (!gaps) check({tag, ".no_bubbles"}, 32'(tw), 32'd0);
    @(negedge clk);
    check({tag, ".cpu_rst_fall"}, 32'(bus.cpu_rst), 32'd0);
    check({tag, ".we_low"}, 32'(bus.mem_we), 32'd0);
    repeat (3) @(negedge clk);
    check_writes(tag);
    if (wr_q.size() > 0 && !gaps) check({tag, ".ready_in_wr"}, 32'(wr_q[0].rdy), 32'd1);
    check({tag, ".busy_end"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".mem_we"},    32'(bus.mem_we),    32'd0);
    check({tag, ".mem_addr"},  32'(bus.mem_addr),  32'd0);
    check({tag, ".mem_wdata"}, bus.mem_wdata,      32'd0);
    check({tag, ".cpu_rst"},   32'(bus.cpu_rst),   32'd1);
    check({tag, ".busy"},      32'(bus.busy),      32'd0);
    check({tag, ".done"},      32'(bus.done),      32'd0);
    check({tag, ".err"},       32'(bus.err),       32'd0);
    check({tag, ".in_ready"},  32'(bus.in_ready),  32'd0);
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    int tw;
    bit exp_busy;

    tbl[0] = '{"n0",      16'd0,     1'b0, 1'b1, 1'b0, 0};
    tbl[1] = '{"n1",      16'd1,     1'b0, 1'b1, 1'b0, 1};
    tbl[2] = '{"n2_gaps", 16'd2,     1'b1, 1'b1, 1'b0, 2};
    tbl[3] = '{"n5_gaps", 16'd5,     1'b1, 1'b1, 1'b0, 5};
    tbl[4] = '{"n_cap",   16'd4096,  1'b0, 1'b1, 1'b0, 4096};
    tbl[5] = '{"n_cap+1", 16'h1001,  1'b0, 1'b0, 1'b1, 0};
    tbl[6] = '{"n_max",   16'hFFFF,  1'b1, 1'b0, 1'b1, 0};

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset values, then in_ready rising one cycle after release.
    #1 rst_async = 1'b1;
    #3;
    check_reset_values("rst");
    repeat (2) @(negedge clk);
    rst_async = 1'b0;
    check("rst.ready_at_release", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check("rst.ready_after", 32'(bus.in_ready), 32'd1);

    // Known two-word image, continuous and with random valid gaps.
    fixed_stream(1'b0, "fixed");
    fixed_stream(1'b1, "fixed_gaps");

    // Table: random images of assorted sizes including capacity limits.
    foreach (tbl[v]) begin
      apply_reset();
      model_load(tbl[v].n);
      drive_stream(tbl[v].gaps, tw);
      bus.in_valid = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      exp_busy = (int'(tbl[v].n) <= CAP);
`else
      exp_busy = (tbl[v].n != 16'd0) && (int'(tbl[v].n) <= CAP);
`endif
      check({tbl[v].name, ".busy_hdr"}, 32'(hdr_busy), 32'(exp_busy));
      if (!tbl[v].gaps) check({tbl[v].name, ".no_bubbles"}, 32'(tw), 32'd0);
      repeat (4) @(negedge clk);
      check({tbl[v].name, ".done"},     32'(bus.done),     32'(tbl[v].exp_done));
      check({tbl[v].name, ".err"},      32'(bus.err),      32'(tbl[v].exp_err));
      check({tbl[v].name, ".cpu_rst"},  32'(bus.cpu_rst),  32'(!tbl[v].exp_done));
      check({tbl[v].name, ".in_ready"}, 32'(bus.in_ready), 32'd0);
      check({tbl[v].name, ".busy"},     32'(bus.busy),     32'd0);
      check({tbl[v].name, ".tbl_writes"}, 32'(wr_q.size()), 32'(tbl[v].exp_writes));
      check_writes(tbl[v].name);
    end

    // Asynchronous reset after 2 of 3 words, then a clean 1-word load.
    apply_reset();
    model_load(16'd3);
    for (int i = 0; i < 10; i++) send_byte(stim_q[i], 1'b0, tw);
    check("abort.we_before", 32'(bus.mem_we), 32'd1);
    check("abort.busy_before", 32'(bus.busy), 32'd1);
    #2 rst_async = 1'b1;
    #1;
    check_reset_values("abort");
    @(negedge clk);
    rst_async = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    wr_q.delete();
    model_load(16'd1);
    drive_stream(1'b0, tw);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reload.done", 32'(bus.done), 32'd1);
    check("reload.cpu_rst", 32'(bus.cpu_rst), 32'd0);
    check_writes("reload");

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Good and bad trailing checksum on a 1-word image.
    for (int c = 0; c < 2; c++) begin
      apply_reset();
      stim_q    = '{8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, (c == 0) ? 8'hFE : 8'hFF};
      exp_words = '{32'h00000001};
      drive_stream(1'b0, tw);
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check($sformatf("csum%0d.done", c),    32'(bus.done),    32'(c == 0));
      check($sformatf("csum%0d.err", c),     32'(bus.err),     32'(c == 1));
      check($sformatf("csum%0d.cpu_rst", c), 32'(bus.cpu_rst), 32'(c == 1));
      check_writes($sformatf("csum%0d", c));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the 32-bit instruction memory. The pipelined core only ever reads that memory; this block fills it.
- Accepts a byte stream through a valid/ready handshake, parses a word-count header, assembles little-endian 32-bit words and writes them to consecutive word addresses.
- Holds the core in reset until the image is completely loaded.
- Sits between the host byte source (UART RX or debug bridge) and the instruction memory's spare write port.

Parameters:
ADDR_W, 12, word-address width of instruction memory; capacity is 2**ADDR_W words (4096).
CNT_W, 16, width of the header word-count field in bits; must be ≥ ADDR_W+1.

Ports:
clk  input  1  system clock
rst_async  input  1  asynchronous, active-high reset
in_valid  input  1  byte available from source
in_data  input  8  byte value
in_ready  output  1  loader accepts byte this cycle (transfer = in_valid & in_ready)
mem_addr  output  ADDR_W  instruction-memory word address
mem_wdata  output  32  word to write
mem_we  output  1  one-cycle write strobe
cpu_rst  output  1  core reset hold; high until load completes
busy  output  1  load in progress (header received, image not finished)
done  output  1  image loaded successfully (sticky)
err  output  1  load aborted (sticky)

Behaviour:
- Reset: all state elements use the asynchronous reset.
  - Reset values: state=HDR0, mem_addr=0, mem_wdata=0, mem_we=0, cpu_rst=1, busy=0, done=0, err=0.
  - in_ready is registered and resets to 0; it rises the first cycle after reset releases.
- States: HDR0 → HDR1 → WORD → (CSUM) → DONE | ERR.
- HDR0: accept one byte as count[15:8], then go to HDR1.
- HDR1: accept one byte as count[7:0].
  - N=0: go to DONE (or CSUM when the option is enabled).
  - N>2**ADDR_W: go to ERR.
  - Otherwise: go to WORD with busy=1.
- WORD: byte index k=0..3 with wrap.
  - Byte k goes to bits [8k+7:8k] of the assembly register (little-endian).
  - On acceptance of byte 3: the next cycle mem_wdata=assembled word, mem_addr=current index, mem_we=1 for exactly one cycle. The index then increments.
  - in_ready stays high during that write cycle; byte 0 of the next word may be accepted in the same cycle, so there are no bubbles.
  - After write N-1, go to DONE (or CSUM). mem_addr holds its last written value; it never wraps, because N ≤ capacity is enforced.
- DONE and ERR are terminal until rst_async.
  - In both states: in_ready=0 and busy=0.
  - DONE: done=1, and cpu_rst falls one cycle after DONE is entered. The core therefore never sees a partially written image.
  - ERR: err=1 and cpu_rst stays 1.
- No transfer occurs while in_valid=0. State and partial words are held indefinitely; there is no timeout.
- The word counter is CNT_W+1 bits wide, so N=2**ADDR_W loads exactly the full memory.
- rst_async asserted mid-load aborts immediately: mem_we=0 and everything returns to reset values. Memory contents are not cleared.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum covers every accepted byte, header included.
  - After the last word (or after the header when N=0) the CSUM state accepts one trailing byte.
  - If (sum + byte) mod 256 == 0, go to DONE; otherwise go to ERR.
  - Words are still written before the check; only cpu_rst release depends on the check.
- Undefined: there is no CSUM state and no trailing byte, and the sum register is not synthesised.

Decomposition:
- Shared package: state encoding constants (HDR0, HDR1, WORD, CSUM, DONE, ERR), the default word-count width, and the instruction-memory ADDR_W shared with the core's memory instance.
- Sub-module: imem_loader_asm, the byte-to-word assembler (byte index, shift register, word_valid pulse).
- The FSM, address counter and reset-hold logic stay in the top module.

Test Plan:
- Header 00 02; bytes 78 56 34 12 EF BE AD DE with in_valid held high → writes addr0=0x12345678, addr1=0xDEADBEEF; mem_we high for exactly 2 cycles; done=1; cpu_rst falls 1 cycle after DONE.
- Same stream with in_valid toggled randomly each cycle → identical writes, no extra or duplicated strobes.
- Header 00 00 → no mem_we; DONE reached after 2 bytes; cpu_rst deasserts.
- Header 10 01 (N=4097, ADDR_W=12) → err=1, in_ready=0, cpu_rst stays 1, no writes.
- rst_async pulse after 2 of 3 words → outputs return to reset values; a subsequent 1-word load writes addr0 correctly.
- With IMEM_LOADER_CHECKSUM_EN: header 00 01, word bytes 01 00 00 00, checksum FE → DONE. Same stream with checksum FF → ERR, word still written, cpu_rst held at 1.
